// File: rtl/hazard_ctrl.sv
// Purpose: hazard/sequencing control for the 5-stage MIPS pipeline: forwarding selects, load-use and MDU interlocks, branch flush.
// Latency: forwarding and stall/clear controls are combinational; MDU busy tracking is registered (busy MDU_LAT-1 cycles after start).
// Backpressure: stalls IF/ID on a load-use hazard (one cycle) or on an HI/LO consumer while the MDU is busy; a taken branch overrides stalls.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   valid_id_i, rs_id_i, rt_id_i    ID-stage instruction and its sources
//   mdu_use_id_i                    ID instruction reads HI/LO or is a mult/div
//   valid_ex_i .. mdu_start_ex_i    EX-stage instruction fields and control
//   dst_mem_i, reg_wr_mem_i         MEM-stage write-back target
//   dst_wb_i, reg_wr_wb_i           WB-stage write-back target
//   stall_if_o, stall_id_o          hold PC / IF/ID and the ID instruction
//   clr_id_o, clr_ex_o              clear IF/ID and ID/EX registers
//   fwd_a_o, fwd_b_o                EX operand selects: 00 regfile, 01 WB, 10 MEM
//   mdu_busy_o                      MDU result not yet available
// Optional build macro HAZ_PERF_CNT_EN adds stall_cnt_o and flush_cnt_o
// (cycles with stall_id_o high, cycles with branch_taken_ex_i high; both wrap).

module hazard_ctrl #(
    parameter int MDU_LAT = 8,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_id_i,
    input  logic [4:0] rs_id_i,
    input  logic [4:0] rt_id_i,
    input  logic       mdu_use_id_i,
    input  logic       valid_ex_i,
    input  logic [4:0] rs_ex_i,
    input  logic [4:0] rt_ex_i,
    input  logic [4:0] dst_ex_i,
    input  logic       reg_wr_ex_i,
    input  logic       mem_to_reg_ex_i,
    input  logic       branch_taken_ex_i,
    input  logic       mdu_start_ex_i,
    input  logic [4:0] dst_mem_i,
    input  logic       reg_wr_mem_i,
    input  logic [4:0] dst_wb_i,
    input  logic       reg_wr_wb_i,
    output logic       stall_if_o,
    output logic       stall_id_o,
    output logic       clr_id_o,
    output logic       clr_ex_o,
    output logic [1:0] fwd_a_o,
    output logic [1:0] fwd_b_o,
    output logic       mdu_busy_o
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(MDU_LAT - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    mdu_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             mdu_go;
    logic             lu;
    logic             md;
    logic             hold;
    logic             wr_mem_ok;
    logic             wr_wb_ok;

    // ------------------------------------------------------------------
    // Forwarding: the MEM result is younger than WB, so it wins.
    // Register 0 is never forwarded since it always reads as zero.
    // ------------------------------------------------------------------
    assign wr_mem_ok = reg_wr_mem_i && (dst_mem_i != 5'd0);
    assign wr_wb_ok  = reg_wr_wb_i  && (dst_wb_i  != 5'd0);

    always_comb begin
        fwd_a_o = 2'b00;
        if (wr_mem_ok && (dst_mem_i == rs_ex_i)) begin
            fwd_a_o = 2'b10;
        end else if (wr_wb_ok && (dst_wb_i == rs_ex_i)) begin
            fwd_a_o = 2'b01;
        end
    end

    always_comb begin
        fwd_b_o = 2'b00;
        if (wr_mem_ok && (dst_mem_i == rt_ex_i)) begin
            fwd_b_o = 2'b10;
        end else if (wr_wb_ok && (dst_wb_i == rt_ex_i)) begin
            fwd_b_o = 2'b01;
        end
    end

    // ------------------------------------------------------------------
    // MDU busy tracker. The counter holds the cycles left before the
    // result is readable; leaving BUSY on the count-of-1 edge lands the
    // counter on 0 exactly as the FSM returns to IDLE.
    // ------------------------------------------------------------------
    assign mdu_go = mdu_start_ex_i && valid_ex_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (mdu_go) begin
                    state_nxt = BUSY;
                    cnt_nxt   = RELOAD;
                end
            end
            BUSY: begin
                if (mdu_go) begin
                    // Back-to-back issue restarts the latency window.
                    cnt_nxt = RELOAD;
                end else if (cnt == ONE) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign mdu_busy_o = (state == BUSY);

    // ------------------------------------------------------------------
    // Interlocks. A taken branch squashes the ID instruction anyway, so
    // its redirect must never be frozen by a stall on that instruction.
    // reg_wr_ex_i is implied by mem_to_reg_ex_i for the load-use check.
    // ------------------------------------------------------------------
    assign lu = valid_ex_i && mem_to_reg_ex_i && (dst_ex_i != 5'd0) && valid_id_i
                && ((dst_ex_i == rs_id_i) || (dst_ex_i == rt_id_i))
                && (reg_wr_ex_i || !reg_wr_ex_i);
    assign md = mdu_busy_o && valid_id_i && mdu_use_id_i;

    assign hold       = (lu || md) && !branch_taken_ex_i;
    assign stall_if_o = hold;
    assign stall_id_o = hold;
    assign clr_id_o   = branch_taken_ex_i;
    assign clr_ex_o   = lu || md || branch_taken_ex_i;

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_id_o) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (branch_taken_ex_i) begin
                flush_cnt_o <= flush_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic       valid_id_i;
    logic [4:0] rs_id_i;
    logic [4:0] rt_id_i;
    logic       mdu_use_id_i;
    logic       valid_ex_i;
    logic [4:0] rs_ex_i;
    logic [4:0] rt_ex_i;
    logic [4:0] dst_ex_i;
    logic       reg_wr_ex_i;
    logic       mem_to_reg_ex_i;
    logic       branch_taken_ex_i;
    logic       mdu_start_ex_i;
    logic [4:0] dst_mem_i;
    logic       reg_wr_mem_i;
    logic [4:0] dst_wb_i;
    logic       reg_wr_wb_i;
    logic       stall_if_o;
    logic       stall_id_o;
    logic       clr_id_o;
    logic       clr_ex_o;
    logic [1:0] fwd_a_o;
    logic [1:0] fwd_b_o;
    logic       mdu_busy_o;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.MDU_LAT(8), .CNT_W(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .valid_id_i        (valid_id_i),
        .rs_id_i           (rs_id_i),
        .rt_id_i           (rt_id_i),
        .mdu_use_id_i      (mdu_use_id_i),
        .valid_ex_i        (valid_ex_i),
        .rs_ex_i           (rs_ex_i),
        .rt_ex_i           (rt_ex_i),
        .dst_ex_i          (dst_ex_i),
        .reg_wr_ex_i       (reg_wr_ex_i),
        .mem_to_reg_ex_i   (mem_to_reg_ex_i),
        .branch_taken_ex_i (branch_taken_ex_i),
        .mdu_start_ex_i    (mdu_start_ex_i),
        .dst_mem_i         (dst_mem_i),
        .reg_wr_mem_i      (reg_wr_mem_i),
        .dst_wb_i          (dst_wb_i),
        .reg_wr_wb_i       (reg_wr_wb_i),
        .stall_if_o        (stall_if_o),
        .stall_id_o        (stall_id_o),
        .clr_id_o          (clr_id_o),
        .clr_ex_o          (clr_ex_o),
        .fwd_a_o           (fwd_a_o),
        .fwd_b_o           (fwd_b_o),
        .mdu_busy_o        (mdu_busy_o)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cnt_o       (stall_cnt_o),
        .flush_cnt_o       (flush_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {stall_if, stall_id, clr_id, clr_ex, fwd_a[1:0], fwd_b[1:0], mdu_busy}
    function automatic logic [8:0] outs();
        return {stall_if_o, stall_id_o, clr_id_o, clr_ex_o, fwd_a_o, fwd_b_o, mdu_busy_o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge; checks happen 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_id_i = 0; rs_id_i = 0; rt_id_i = 0; mdu_use_id_i = 0;
        valid_ex_i = 0; rs_ex_i = 0; rt_ex_i = 0; dst_ex_i = 0;
        reg_wr_ex_i = 0; mem_to_reg_ex_i = 0; branch_taken_ex_i = 0;
        mdu_start_ex_i = 0; dst_mem_i = 0; reg_wr_mem_i = 0;
        dst_wb_i = 0; reg_wr_wb_i = 0;
    endtask

    task automatic set_load_use(input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt);
        valid_ex_i = 1; mem_to_reg_ex_i = 1; reg_wr_ex_i = 1; dst_ex_i = dst;
        valid_id_i = 1; rs_id_i = rs; rt_id_i = rt;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        #2;
        chk("reset_outs", 32'(outs()), 32'h0);
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("post_reset_outs", 32'(outs()), 32'h0);

        // Forwarding priority
        reg_wr_mem_i = 1; dst_mem_i = 5; reg_wr_wb_i = 1; dst_wb_i = 5;
        rs_ex_i = 5; rt_ex_i = 5;
        #1;
        chk("fwd_mem_a", 32'(fwd_a_o), 32'h2);
        chk("fwd_mem_b", 32'(fwd_b_o), 32'h2);
        dst_mem_i = 0;
        #1;
        chk("fwd_wb_a", 32'(fwd_a_o), 32'h1);
        chk("fwd_wb_b", 32'(fwd_b_o), 32'h1);
        dst_wb_i = 0;
        #1;
        chk("fwd_none_a", 32'(fwd_a_o), 32'h0);
        chk("fwd_none_b", 32'(fwd_b_o), 32'h0);
        dst_mem_i = 6; dst_wb_i = 5; rt_ex_i = 6;
        #1;
        chk("fwd_split", 32'({fwd_a_o, fwd_b_o}), 32'b0110);
        reg_wr_mem_i = 0; reg_wr_wb_i = 0;
        #1;
        chk("fwd_no_wr", 32'({fwd_a_o, fwd_b_o}), 32'b0000);
        idle_inputs();

        // Load-use on rt: one-cycle stall, then the load has moved on
        tick();
        set_load_use(8, 3, 8);
        #1;
        chk("lu_rt", 32'(outs()), 32'b1_1_0_1_00_00_0);
        tick();
        valid_ex_i = 0; mem_to_reg_ex_i = 0; reg_wr_ex_i = 0; dst_ex_i = 0;
        #1;
        chk("lu_released", 32'(outs()), 32'h0);
        set_load_use(9, 9, 2);
        #1;
        chk("lu_rs", 32'(outs()), 32'b1_1_0_1_00_00_0);
        set_load_use(0, 0, 0);
        #1;
        chk("lu_r0", 32'(outs()), 32'h0);
        set_load_use(8, 3, 8);
        mem_to_reg_ex_i = 0;
        #1;
        chk("lu_not_load", 32'(outs()), 32'h0);
        set_load_use(8, 3, 8);
        valid_id_i = 0;
        #1;
        chk("lu_id_invalid", 32'(outs()), 32'h0);

        // Branch overrides load-use stall
        set_load_use(8, 3, 8);
        branch_taken_ex_i = 1;
        #1;
        chk("br_over_lu", 32'(outs()), 32'b0_0_1_1_00_00_0);
        idle_inputs();

        // MDU wait: start, then an HI/LO consumer sits in ID
        tick();
        valid_ex_i = 1; mdu_start_ex_i = 1;
        #1;
        chk("mdu_start_not_busy_yet", 32'(mdu_busy_o), 32'h0);
        tick();
        valid_ex_i = 0; mdu_start_ex_i = 0;
        for (int i = 1; i <= 7; i++) begin
            valid_id_i = 1;
            mdu_use_id_i = (i != 3);
            #1;
            if (i != 3)
                chk($sformatf("mdu_hold_%0d", i), 32'(outs()), 32'b1_1_0_1_00_00_1);
            else
                chk("mdu_busy_no_use", 32'(outs()), 32'b0_0_0_0_00_00_1);
            tick();
        end
        mdu_use_id_i = 1;
        #1;
        chk("mdu_released", 32'(outs()), 32'h0);
        idle_inputs();

        // Restart while busy extends the window to 7 cycles from the restart
        valid_ex_i = 1; mdu_start_ex_i = 1;
        tick();
        mdu_start_ex_i = 0;
        tick(); tick();
        mdu_start_ex_i = 1;
        tick();
        mdu_start_ex_i = 0; valid_ex_i = 0;
        for (int i = 1; i <= 6; i++) tick();
        #1;
        chk("mdu_restart_last", 32'(mdu_busy_o), 32'h1);
        tick();
        chk("mdu_restart_done", 32'(mdu_busy_o), 32'h0);

        // Branch and MDU start together: flush now and MDU starts
        valid_ex_i = 1; mdu_start_ex_i = 1; branch_taken_ex_i = 1;
        #1;
        chk("br_start_flush", 32'(outs()), 32'b0_0_1_1_00_00_0);
        tick();
        idle_inputs();
        #1;
        chk("br_start_busy", 32'(mdu_busy_o), 32'h1);

        // Reset 3 cycles after start: busy drops with no clock edge
        tick(); tick();
        chk("pre_reset_busy", 32'(mdu_busy_o), 32'h1);
        reset = 1'b1;
        #1;
        chk("async_reset_outs", 32'(outs()), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        chk("after_reset_idle", 32'(outs()), 32'h0);

`ifdef HAZ_PERF_CNT_EN
        reset = 1'b1;
        #1;
        reset = 1'b0;
        chk("perf_reset", 32'({stall_cnt_o[15:0], flush_cnt_o[15:0]}), 32'h0);
        for (int i = 0; i < 3; i++) begin
            set_load_use(8, 8, 1);
            tick();
            idle_inputs();
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            branch_taken_ex_i = 1;
            tick();
            idle_inputs();
            tick();
        end
        chk("perf_stall_cnt", stall_cnt_o, 32'd3);
        chk("perf_flush_cnt", flush_cnt_o, 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
